// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register window layout,
// default base address and the fixed source assignments.
package irq_ctrl_pkg;

  localparam logic [31:0] IRQ_BASE_DEFAULT = 32'h0000_7f20;

  localparam logic [3:0] IRQ_PEND  = 4'h0;
  localparam logic [3:0] IRQ_MASK  = 4'h4;
  localparam logic [3:0] IRQ_MODE  = 4'h8;
  localparam logic [3:0] IRQ_CLAIM = 4'hc;

  localparam int unsigned IRQ_TC1 = 0;
  localparam int unsigned IRQ_TC2 = 1;
  localparam int unsigned IRQ_EXT = 2;

  localparam int unsigned IRQ_HWINT_W = 6;

  typedef struct packed {
    logic       valid;
    logic [4:0] id;
  } irq_claim_t;

  // Word index of a byte offset; the two low address bits never select a register.
  function automatic logic [1:0] irq_word(input logic [3:0] off);
    return off[3:2];
  endfunction

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the index
// of the lowest set request.
module irq_prio_enc #(
  parameter int unsigned W = 6
) (
  input  logic [W-1:0] req,
  output logic         valid,
  output logic [4:0]   id
);

  // Scan from the top down so the lowest set index is the last one to land.
  always_comb begin
    valid = 1'b0;
    id    = 5'd0;
    for (int i = W - 1; i >= 0; i--) begin
      valid = valid | req[i];
      id    = req[i] ? 5'(i) : id;
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: per-source pending latch (level or
// rising edge), mask, HWInt vector to CP0 and a retiring claim register.
module irq_ctrl import irq_ctrl_pkg::*; #(
  parameter int unsigned NSRC = 6,
  parameter logic [31:0] BASE = IRQ_BASE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  input  logic [3:0]             byteen,
  input  logic                   rd_en,
  output logic [31:0]            rdata,
  output logic                   sel,
  input  logic [NSRC-1:0]        irq_src,
  output logic [IRQ_HWINT_W-1:0] hw_int,
  output logic                   irq_any
);

  localparam logic [1:0] W_PEND  = irq_word(IRQ_PEND);
  localparam logic [1:0] W_MASK  = irq_word(IRQ_MASK);
  localparam logic [1:0] W_MODE  = irq_word(IRQ_MODE);
  localparam logic [1:0] W_CLAIM = irq_word(IRQ_CLAIM);

  logic [NSRC-1:0]        pend_r, mask_r, mode_r, src_q_r;
  logic [NSRC-1:0]        pend_nx_s, mask_nx_s, mode_nx_s;
  logic [NSRC-1:0]        enabled_s, set_s, clr_s, claim_mask_s;
  logic [IRQ_HWINT_W-1:0] hw_int_r, hw_nx_s;
  logic                   irq_any_r;
  logic                   sel_s, wr_s, claim_s;
  logic [1:0]             word_s;
  logic [31:0]            rdata_s;
  irq_claim_t             claim_s_info;
  logic                   unused_s;

  assign unused_s = ^{addr[1:0], wdata[31:NSRC], byteen[3:1]};

  // The window is 16-byte aligned, so the upper address bits alone decode it.
  assign sel_s     = (addr[31:4] == BASE[31:4]);
  assign word_s    = addr[3:2];
  assign wr_s      = sel_s & byteen[0];
  assign enabled_s = pend_r & mask_r;

  irq_prio_enc #(.W(NSRC)) u_prio (
    .req   (enabled_s),
    .valid (claim_s_info.valid),
    .id    (claim_s_info.id)
  );

  assign claim_s      = rd_en & sel_s & (word_s == W_CLAIM) & claim_s_info.valid;
  assign claim_mask_s = claim_s ? (NSRC'(1) << claim_s_info.id) : {NSRC{1'b0}};
  assign set_s        = irq_src & ~src_q_r;
  assign clr_s        = (wdata[NSRC-1:0] & {NSRC{wr_s & (word_s == W_PEND)}}) | claim_mask_s;

  // Next register state; in edge mode a fresh edge beats a same-cycle clear.
  always_comb begin
    pend_nx_s = (mode_r & (set_s | (pend_r & ~clr_s))) | (~mode_r & irq_src);
    if (wr_s && (word_s == W_MASK)) begin
      mask_nx_s = wdata[NSRC-1:0];
    end else begin
      mask_nx_s = mask_r;
    end
    if (wr_s && (word_s == W_MODE)) begin
      mode_nx_s = wdata[NSRC-1:0];
    end else begin
      mode_nx_s = mode_r;
    end
    hw_nx_s            = {IRQ_HWINT_W{1'b0}};
    hw_nx_s[NSRC-1:0]  = pend_nx_s & mask_nx_s;
  end

  // Register state; hw_int is registered from next-state so it tracks PEND & MASK exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_r    <= {NSRC{1'b0}};
      mask_r    <= {NSRC{1'b0}};
      mode_r    <= {NSRC{1'b0}};
      src_q_r   <= {NSRC{1'b0}};
      hw_int_r  <= {IRQ_HWINT_W{1'b0}};
      irq_any_r <= 1'b0;
    end else begin
      pend_r    <= pend_nx_s;
      mask_r    <= mask_nx_s;
      mode_r    <= mode_nx_s;
      src_q_r   <= irq_src;
      hw_int_r  <= hw_nx_s;
      irq_any_r <= |hw_nx_s;
    end
  end

  // Read mux; unused bits and out-of-window addresses read as zero.
  always_comb begin
    rdata_s = 32'd0;
    if (sel_s) begin
      case (word_s)
        W_PEND:  rdata_s[NSRC-1:0] = pend_r;
        W_MASK:  rdata_s[NSRC-1:0] = mask_r;
        W_MODE:  rdata_s[NSRC-1:0] = mode_r;
        W_CLAIM: rdata_s = {claim_s_info.valid, 26'd0, claim_s_info.id};
        default: rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign rdata   = rdata_s;
  assign sel     = sel_s;
  assign hw_int  = hw_int_r;
  assign irq_any = irq_any_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with literal expectations, then
// randomized bus/source traffic checked every cycle against a rule-level model.
module tb_irq_ctrl;

  localparam int          NSRC = 6;
  localparam logic [31:0] BASE = 32'h0000_7f20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  byteen = 4'd0;
  logic        rd_en = 1'b0;
  logic [31:0] rdata;
  logic        sel;
  logic [5:0]  irq_src = 6'd0;
  logic [5:0]  hw_int;
  logic        irq_any;

  int n_vec = 0;
  int n_bad = 0;

  irq_ctrl #(.NSRC(NSRC), .BASE(BASE)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .byteen(byteen),
    .rd_en(rd_en), .rdata(rdata), .sel(sel), .irq_src(irq_src),
    .hw_int(hw_int), .irq_any(irq_any)
  );

  always #5 clk = ~clk;

  // Reference state, one bit per source.
  bit [5:0] m_pend, m_mask, m_mode, m_srcq;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit in_win(logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd16);
  endfunction

  function automatic int lowest_enabled();
    for (int i = 0; i < NSRC; i++)
      if (m_pend[i] && m_mask[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] exp_rdata(logic [31:0] a);
    int off;
    int id;
    if (!in_win(a)) return 32'd0;
    off = int'((a - BASE) >> 2);
    case (off)
      0: return {26'd0, m_pend};
      1: return {26'd0, m_mask};
      2: return {26'd0, m_mode};
      default: begin
        id = lowest_enabled();
        if (id < 0) return 32'd0;
        return 32'h8000_0000 | 32'(id);
      end
    endcase
  endfunction

  // Model update from the register rules, using the inputs seen at this edge.
  always @(posedge clk) begin : model_upd
    bit [5:0] np;
    int off;
    int id;
    bit wr;
    bit rose;
    bit clr;
    if (reset) begin
      m_pend = 6'd0; m_mask = 6'd0; m_mode = 6'd0; m_srcq = 6'd0;
    end else begin
      off = in_win(addr) ? int'((addr - BASE) >> 2) : -1;
      wr  = (off >= 0) && byteen[0];
      id  = (rd_en && off == 3) ? lowest_enabled() : -1;
      for (int i = 0; i < NSRC; i++) begin
        if (!m_mode[i]) begin
          np[i] = irq_src[i];
        end else begin
          rose = irq_src[i] && !m_srcq[i];
          clr  = (wr && off == 0 && wdata[i]) || (id == i);
          np[i] = rose ? 1'b1 : (clr ? 1'b0 : m_pend[i]);
        end
      end
      if (wr && off == 1) m_mask = wdata[5:0];
      if (wr && off == 2) m_mode = wdata[5:0];
      m_pend = np;
      m_srcq = irq_src;
    end
  end

  // Every cycle: all outputs against the model, mid-cycle.
  always @(negedge clk) begin : compare
    bit [5:0] eh;
    eh = m_pend & m_mask;
    check("hw_int",  {26'd0, hw_int},  {26'd0, eh});
    check("irq_any", {31'd0, irq_any}, {31'd0, |eh});
    check("sel",     {31'd0, sel},     {31'd0, in_win(addr)});
    check("rdata",   rdata,            exp_rdata(addr));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d);
    addr = a; wdata = d; byteen = 4'h1;
    tick();
    byteen = 4'h0; wdata = 32'd0;
  endtask

  task automatic rd_chk(string nm, logic [31:0] a, logic [31:0] e);
    addr = a; rd_en = 1'b1;
    @(negedge clk);
    check(nm, rdata, e);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic expect_hw(string nm, logic [5:0] e);
    @(negedge clk);
    check(nm, {26'd0, hw_int}, {26'd0, e});
    tick();
  endtask

  initial begin
    int r;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    rd_chk("rst_pend",  32'h7f20, 32'd0);
    rd_chk("rst_mask",  32'h7f24, 32'd0);
    rd_chk("rst_mode",  32'h7f28, 32'd0);
    rd_chk("rst_claim", 32'h7f2c, 32'd0);
    expect_hw("rst_hw", 6'd0);

    // Single edge, then claim retires it
    wr(32'h7f28, 32'h3); wr(32'h7f24, 32'h3);
    irq_src = 6'b000010; tick(); irq_src = 6'd0;
    expect_hw("edge_hw", 6'b000010);
    rd_chk("edge_pend", 32'h7f20, 32'h2);
    rd_chk("claim1", 32'h7f2c, 32'h8000_0001);
    expect_hw("claim_clr", 6'd0);

    // Simultaneous edges, claimed in priority order
    irq_src = 6'b000011; tick(); irq_src = 6'd0;
    rd_chk("prio_a", 32'h7f2c, 32'h8000_0000);
    rd_chk("prio_b", 32'h7f2c, 32'h8000_0001);
    rd_chk("prio_c", 32'h7f2c, 32'h0);

    // Level mode ignores W1C and follows the source
    wr(32'h7f28, 32'h0); wr(32'h7f24, 32'h4);
    irq_src = 6'b000100; tick();
    expect_hw("lvl_on", 6'b000100);
    wr(32'h7f20, 32'h4);
    expect_hw("lvl_w1c", 6'b000100);
    irq_src = 6'd0;
    expect_hw("lvl_hold", 6'b000100);
    expect_hw("lvl_drop", 6'd0);

    // Masked edge still latches; set wins over W1C
    wr(32'h7f28, 32'h1); wr(32'h7f24, 32'h0);
    irq_src = 6'b000001; tick(); irq_src = 6'd0;
    expect_hw("masked_hw", 6'd0);
    rd_chk("masked_pend", 32'h7f20, 32'h1);
    wr(32'h7f24, 32'h1);
    expect_hw("unmask_hw", 6'b000001);
    irq_src = 6'b000001; wr(32'h7f20, 32'h1); irq_src = 6'd0;
    rd_chk("setwins", 32'h7f20, 32'h1);
    wr(32'h7f20, 32'h1);
    rd_chk("w1c_edge", 32'h7f20, 32'h0);

    // Reset with a source held high: no spurious edge afterwards
    wr(32'h7f28, 32'h3);
    irq_src = 6'b000011; tick(); irq_src = 6'b000001; tick();
    rd_chk("pre_rst", 32'h7f20, 32'h3);
    reset = 1'b1; tick(); reset = 1'b0;
    rd_chk("post_rst", 32'h7f20, 32'h0);
    wr(32'h7f28, 32'h1);
    wr(32'h7f20, 32'h1);
    tick(); tick(); tick();
    rd_chk("no_relatch", 32'h7f20, 32'h0);
    irq_src = 6'd0; tick(); irq_src = 6'b000001; tick();
    rd_chk("relatch", 32'h7f20, 32'h1);
    irq_src = 6'd0;

    // Out-of-window, unaligned and non-byte-0 accesses
    wr(32'h7f24, 32'h15);
    wr(32'h7f34, 32'h3f);
    addr = 32'h7f30;
    @(negedge clk);
    check("oow_sel", {31'd0, sel}, 32'd0);
    tick();
    addr = 32'h7f24; wdata = 32'h3f; byteen = 4'h2; tick(); byteen = 4'h0;
    rd_chk("mask_kept", 32'h7f24, 32'h15);
    rd_chk("unaligned", 32'h7f25, 32'h15);

    // Randomized traffic, checked by the per-cycle compare
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 299) == 0);
      r = $urandom_range(0, 9);
      if (r == 0)      addr = $urandom;
      else if (r == 1) addr = BASE + 32'd16 + 32'($urandom_range(0, 3));
      else if (r == 2) addr = BASE - 32'd4;
      else             addr = BASE + 32'($urandom_range(0, 15));
      byteen = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      wdata  = $urandom;
      rd_en  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) irq_src = 6'($urandom);
      tick();
    end
    reset = 1'b0; rd_en = 1'b0; byteen = 4'h0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
